// File: rtl/dmi_router.sv
// DMI fabric: one DTM-side channel routed to N_DM debug-module channels through a request FIFO,
// a local select register and a per-transaction response timeout. DMI_ROUTER_STATS_EN adds a timeout counter.
module dmi_router #(
   parameter int ABITS = 6,
   parameter int DBITS = 32,
   parameter int N_DM = 2,
   parameter int REQ_DEPTH = 4,
   parameter logic [ABITS-1:0] SEL_ADDR = ABITS'(6'h3F),
   parameter int TIMEOUT = 1024,
   localparam int DMI_W = ABITS + DBITS + 2,
   localparam int SEL_W = (N_DM > 1) ? $clog2(N_DM) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_up_req_vld,
   input  logic [DMI_W-1:0]      i_up_req_data,
   output logic                  o_up_req_rdy,
   output logic                  o_up_resp_vld,
   output logic [DMI_W-1:0]      o_up_resp_data,
   input  logic                  i_up_resp_rdy,
   output logic [N_DM-1:0]       o_dn_req_vld,
   output logic [DMI_W-1:0]      o_dn_req_data,
   input  logic [N_DM-1:0]       i_dn_req_rdy,
   input  logic [N_DM-1:0]       i_dn_resp_vld,
   input  logic [N_DM*DMI_W-1:0] i_dn_resp_data,
   output logic [N_DM-1:0]       o_dn_resp_rdy,
   output logic [SEL_W-1:0]      o_sel
);

   // Every channel transfers on the cycle where vld and rdy are both high; a vld source holds
   // its data stable until then and never withdraws vld early (except ISSUE on timeout).
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam int PTR_W = $clog2(REQ_DEPTH) + 1;
   localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   state_t state_q, state_d;
   logic [DMI_W-1:0] fifo_mem [REQ_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             empty, full, push, pop, run_q;
   logic [DMI_W-1:0] head, cur_q, resp_q, loc_resp, tmo_resp, resp_slice;
   logic [ABITS-1:0] head_addr;
   logic [DBITS-1:0] head_data;
   logic [1:0]       head_op;
   logic             head_local, sel_wr;
   logic [SEL_W-1:0] sel_q;
   logic [N_DM-1:0]  sel_oh;
   logic             req_rdy_sel, resp_vld_sel, tmo_hit, tmo_fire;
   logic [31:0]      tmo_cnt;
`ifdef DMI_ROUTER_STATS_EN
   localparam logic [ABITS-1:0] STAT_ADDR = SEL_ADDR - ABITS'(1);
   logic [15:0]      stat_cnt;
   logic             stat_clr;
`endif

   assign empty = (wr_ptr == rd_ptr);
   assign full = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
   assign push = i_up_req_vld && o_up_req_rdy;
   assign pop = (state_q == IDLE) && !empty;
   assign head = fifo_mem[rd_ptr[PTR_W-2:0]];
   assign head_addr = head[DMI_W-1:DBITS+2];
   assign head_data = head[DBITS+1:2];
   assign head_op = head[1:0];
   assign sel_oh = N_DM'(1) << sel_q;
   assign req_rdy_sel = |(i_dn_req_rdy & sel_oh);
   assign resp_vld_sel = |(i_dn_resp_vld & sel_oh);
   assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
   // A handshake or response landing on the final cycle beats the timeout.
   assign tmo_fire = tmo_hit && (((state_q == ISSUE) && !req_rdy_sel) ||
                                 ((state_q == WAIT) && !resp_vld_sel));
   assign tmo_resp = {cur_q[DMI_W-1:DBITS+2], {DBITS{1'b0}}, 2'b10};

   always_comb begin
      resp_slice = '0;
      for (int k = 0; k < N_DM; k++)
         if (sel_q == SEL_W'(k)) resp_slice = i_dn_resp_data[k*DMI_W +: DMI_W];
   end

   // Decode of the FIFO head: requests answered without touching a DM.
   always_comb begin
      head_local = 1'b0;
      sel_wr = 1'b0;
      loc_resp = {head_addr, {DBITS{1'b0}}, 2'b00};
`ifdef DMI_ROUTER_STATS_EN
      stat_clr = 1'b0;
`endif
      if (head_op == 2'd0) begin
         head_local = 1'b1;
      end else if (head_op == 2'd3) begin
         head_local = 1'b1;
         loc_resp[1:0] = 2'b10;
      end else if (head_addr == SEL_ADDR) begin
         head_local = 1'b1;
         if (head_op == 2'd1) loc_resp[DBITS+1:2] = DBITS'(sel_q);
         else if (head_data < DBITS'(N_DM)) sel_wr = 1'b1;
         else loc_resp[1:0] = 2'b10;
      end
`ifdef DMI_ROUTER_STATS_EN
      else if (head_addr == STAT_ADDR) begin
         head_local = 1'b1;
         if (head_op == 2'd1) loc_resp[DBITS+1:2] = DBITS'(stat_cnt);
         else stat_clr = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PTR_W-2:0]] <= i_up_req_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cur_q <= '0;
         resp_q <= '0;
         sel_q <= '0;
         tmo_cnt <= '0;
      end else begin
         run_q <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (state_q == ISSUE || state_q == WAIT) tmo_cnt <= tmo_cnt + 32'd1;
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            cur_q <= head;
            if (head_local) begin
               resp_q <= loc_resp;
               if (sel_wr) sel_q <= head_data[SEL_W-1:0];
            end else begin
               tmo_cnt <= '0;
            end
         end
         if (tmo_fire) resp_q <= tmo_resp;
         else if (state_q == WAIT && resp_vld_sel) resp_q <= resp_slice;
      end
   end

`ifdef DMI_ROUTER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stat_cnt <= '0;
      else if (pop && stat_clr) stat_cnt <= '0;
      else if (tmo_fire && stat_cnt != 16'hFFFF) stat_cnt <= stat_cnt + 16'd1;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (pop) state_d = head_local ? RESP : ISSUE;
         ISSUE: if (req_rdy_sel) state_d = WAIT;
                else if (tmo_fire) state_d = RESP;
         WAIT:  if (resp_vld_sel || tmo_fire) state_d = RESP;
         RESP:  if (i_up_resp_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_up_req_rdy = run_q && !full;
      o_up_resp_vld = (state_q == RESP);
      o_up_resp_data = resp_q;
      o_dn_req_vld = (state_q == ISSUE) ? sel_oh : '0;
      o_dn_req_data = cur_q;
      o_dn_resp_rdy = '0;
      if (run_q) o_dn_resp_rdy = (state_q == WAIT) ? '1 : ~sel_oh;
      o_sel = sel_q;
   end

endmodule

// File: tb/tb_dmi_router.sv
// Directed bench for dmi_router: host driver, per-channel DM responders and an in-order
// response scoreboard. Runs with TIMEOUT = 16.
module tb_dmi_router;
   localparam int ABITS = 6;
   localparam int DBITS = 32;
   localparam int N_DM = 2;
   localparam int DMI_W = ABITS + DBITS + 2;
   localparam logic [5:0] SEL = 6'h3F;
   localparam logic [1:0] RD = 2'd1;
   localparam logic [1:0] WR = 2'd2;

   logic clk = 1'b0;
   logic rst_n;
   logic up_req_vld, up_resp_rdy;
   logic [DMI_W-1:0] up_req_data;
   logic o_up_req_rdy, o_up_resp_vld;
   logic [DMI_W-1:0] o_up_resp_data, o_dn_req_data;
   logic [N_DM-1:0] o_dn_req_vld, o_dn_resp_rdy;
   logic [N_DM-1:0] dm_rdy, dm_mute;
   wire  [N_DM-1:0] dn_resp_vld;
   wire  [N_DM*DMI_W-1:0] dn_resp_data;
   logic [0:0] o_sel;
   int dm_delay;
   logic force_en;
   logic [31:0] force_word;
   logic [N_DM-1:0] seen_vld = '0;

   int checks = 0;
   int errors = 0;
   logic [DMI_W-1:0] exp_q[$];

   // clock and global watchdog
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   dmi_router #(.N_DM(N_DM), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_up_req_vld(up_req_vld), .i_up_req_data(up_req_data), .o_up_req_rdy(o_up_req_rdy),
      .o_up_resp_vld(o_up_resp_vld), .o_up_resp_data(o_up_resp_data), .i_up_resp_rdy(up_resp_rdy),
      .o_dn_req_vld(o_dn_req_vld), .o_dn_req_data(o_dn_req_data), .i_dn_req_rdy(dm_rdy),
      .i_dn_resp_vld(dn_resp_vld), .i_dn_resp_data(dn_resp_data), .o_dn_resp_rdy(o_dn_resp_rdy),
      .o_sel(o_sel)
   );

   function automatic logic [DMI_W-1:0] pkt(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op);
      return {a, d, op};
   endfunction

   function automatic logic [31:0] dm_word(input int k, input logic [5:0] a);
      logic [31:0] w;
      w = 32'hD000_0000;
      w[19:16] = k[3:0];
      w[5:0] = a;
      return w;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // DM responders: answer a handshaken request after dm_delay cycles unless muted.
   for (genvar k = 0; k < N_DM; k++) begin : g_dm
      logic rv = 1'b0;
      logic [DMI_W-1:0] rp = '0;
      logic [DMI_W-1:0] last_req = '0;
      assign dn_resp_vld[k] = rv;
      assign dn_resp_data[k*DMI_W +: DMI_W] = rp;
      always begin
         @(posedge clk);
         if (rst_n && o_dn_req_vld[k] && dm_rdy[k]) begin
            last_req = o_dn_req_data;
            if (!dm_mute[k]) begin
               repeat (dm_delay) @(posedge clk);
               #1;
               rp = pkt(last_req[DMI_W-1:DBITS+2], force_en ? force_word : dm_word(k, last_req[DMI_W-1:DBITS+2]), 2'd0);
               rv = 1'b1;
               @(posedge clk);
               #1 rv = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) seen_vld <= seen_vld | o_dn_req_vld;

   // scoreboard: every accepted upstream response must match the head of exp_q
   always @(negedge clk) begin
      if (rst_n && o_up_resp_vld && up_resp_rdy) begin
         if (exp_q.size() == 0) check("resp_unexpected", 64'(o_up_resp_vld), 64'd0);
         else check("resp_pkt", 64'(o_up_resp_data), 64'(exp_q.pop_front()));
      end
   end

   task automatic send_req(input logic [DMI_W-1:0] p);
      int n;
      n = 0;
      up_req_vld = 1'b1;
      up_req_data = p;
      while (!o_up_req_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_stall", 64'(o_up_req_rdy), 64'd1);
      @(negedge clk);
      up_req_vld = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_up_req_rdy"}, 64'(o_up_req_rdy), 64'd0);
      check({tag, "_up_resp_vld"}, 64'(o_up_resp_vld), 64'd0);
      check({tag, "_up_resp_data"}, 64'(o_up_resp_data), 64'd0);
      check({tag, "_dn_req_vld"}, 64'(o_dn_req_vld), 64'd0);
      check({tag, "_dn_req_data"}, 64'(o_dn_req_data), 64'd0);
      check({tag, "_dn_resp_rdy"}, 64'(o_dn_resp_rdy), 64'd0);
      check({tag, "_sel"}, 64'(o_sel), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      up_req_vld = 1'b0;
      up_req_data = '0;
      up_resp_rdy = 1'b1;
      dm_rdy = '1;
      dm_mute = '0;
      dm_delay = 1;
      force_en = 1'b0;
      force_word = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check("run_up_req_rdy", 64'(o_up_req_rdy), 64'd1);
      check("idle_dn_resp_rdy_sel0", 64'(o_dn_resp_rdy), 64'b10);

      // out-of-range select write is refused
      exp_q.push_back(pkt(SEL, 32'd0, 2'd2));
      send_req(pkt(SEL, 32'd5, WR));
      wait_drain("drain_sel_bad");
      check("sel_after_bad", 64'(o_sel), 64'd0);

      // select write with local response latency, then read back
      exp_q.push_back(pkt(SEL, 32'd0, 2'd0));
      send_req(pkt(SEL, 32'd1, WR));
      check("local_lat_t1", 64'(o_up_resp_vld), 64'd0);
      @(negedge clk);
      check("local_lat_t2", 64'(o_up_resp_vld), 64'd1);
      wait_drain("drain_sel_wr");
      check("sel_after_wr", 64'(o_sel), 64'd1);
      exp_q.push_back(pkt(SEL, 32'd1, 2'd0));
      send_req(pkt(SEL, 32'd0, RD));
      wait_drain("drain_sel_rd");

      // nop and reserved op
      exp_q.push_back(pkt(6'h05, 32'd0, 2'd0));
      send_req(pkt(6'h05, 32'hAB, 2'd0));
      exp_q.push_back(pkt(6'h07, 32'd0, 2'd2));
      send_req(pkt(6'h07, 32'h1234, 2'd3));
      wait_drain("drain_nop_rsv");
      check("idle_dn_resp_rdy_sel1", 64'(o_dn_resp_rdy), 64'b01);

      // forwarded read to DM1
      force_en = 1'b1;
      force_word = 32'hDEADBEEF;
      dm_delay = 3;
      seen_vld = '0;
      exp_q.push_back(pkt(6'h11, 32'hDEADBEEF, 2'd0));
      send_req(pkt(6'h11, 32'd0, RD));
      wait_drain("drain_dm1_rd");
      check("dm1_only_vld", 64'(seen_vld), 64'b10);
      check("dm1_req_pkt", 64'(g_dm[1].last_req), 64'(pkt(6'h11, 32'd0, RD)));
      force_en = 1'b0;
      dm_delay = 1;

      // back to DM0, fill the FIFO behind a stalled DM
      exp_q.push_back(pkt(SEL, 32'd0, 2'd0));
      send_req(pkt(SEL, 32'd0, WR));
      wait_drain("drain_sel0");
      dm_rdy[0] = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         exp_q.push_back(pkt(6'(i), dm_word(0, 6'(i)), 2'd0));
         send_req(pkt(6'(i), 32'd0, RD));
      end
      check("fifo_full_rdy", 64'(o_up_req_rdy), 64'd0);
      dm_rdy[0] = 1'b1;
      wait_drain("drain_backlog");
      check("fifo_rdy_again", 64'(o_up_req_rdy), 64'd1);

      // timeout in WAIT: DM0 accepts but never answers
      dm_mute[0] = 1'b1;
      exp_q.push_back(pkt(6'h22, 32'd0, 2'd2));
      send_req(pkt(6'h22, 32'd0, RD));
      @(negedge clk);
      check("tmo_issue_vld", 64'(o_dn_req_vld), 64'b01);
      repeat (15) @(negedge clk);
      check("tmo_wait_early", 64'(o_up_resp_vld), 64'd0);
      @(negedge clk);
      check("tmo_wait_fire", 64'(o_up_resp_vld), 64'd1);
      wait_drain("drain_tmo_wait");
      dm_mute[0] = 1'b0;

      // timeout in ISSUE: DM0 never ready, vld must be withdrawn
      dm_rdy[0] = 1'b0;
      exp_q.push_back(pkt(6'h24, 32'd0, 2'd2));
      send_req(pkt(6'h24, 32'd0, RD));
      @(negedge clk);
      repeat (15) @(negedge clk);
      check("tmo_issue_still_vld", 64'(o_dn_req_vld), 64'b01);
      @(negedge clk);
      check("tmo_issue_drop_vld", 64'(o_dn_req_vld), 64'b00);
      check("tmo_issue_fire", 64'(o_up_resp_vld), 64'd1);
      wait_drain("drain_tmo_issue");
      dm_rdy[0] = 1'b1;

      exp_q.push_back(pkt(6'h23, dm_word(0, 6'h23), 2'd0));
      send_req(pkt(6'h23, 32'd0, RD));
`ifdef DMI_ROUTER_STATS_EN
      exp_q.push_back(pkt(6'h3E, 32'd2, 2'd0));
`else
      exp_q.push_back(pkt(6'h3E, dm_word(0, 6'h3E), 2'd0));
`endif
      send_req(pkt(6'h3E, 32'd0, RD));
      wait_drain("drain_after_tmo");

      // upstream back-pressure holds the response
      up_resp_rdy = 1'b0;
      exp_q.push_back(pkt(SEL, 32'd0, 2'd0));
      send_req(pkt(SEL, 32'd0, RD));
      repeat (4) @(negedge clk);
      check("hold_vld", 64'(o_up_resp_vld), 64'd1);
      check("hold_data", 64'(o_up_resp_data), 64'(pkt(SEL, 32'd0, 2'd0)));
      up_resp_rdy = 1'b1;
      wait_drain("drain_hold");

      // reset during WAIT on DM1
      exp_q.push_back(pkt(SEL, 32'd0, 2'd0));
      send_req(pkt(SEL, 32'd1, WR));
      wait_drain("drain_sel1_again");
      dm_mute[1] = 1'b1;
      send_req(pkt(6'h30, 32'd0, RD));
      repeat (2) @(negedge clk);
      check("wait_dn_resp_rdy", 64'(o_dn_resp_rdy), 64'b11);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      dm_mute[1] = 1'b0;
      repeat (6) @(negedge clk);
      exp_q.push_back(pkt(SEL, 32'd0, 2'd0));
      send_req(pkt(SEL, 32'd0, RD));
      exp_q.push_back(pkt(6'h31, dm_word(0, 6'h31), 2'd0));
      send_req(pkt(6'h31, 32'd0, RD));
      wait_drain("drain_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
